trap_controller: RTL and testbench



---
 rtl/trap_controller.sv | 157 +++++++++++++++
 tb/tb_trap_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap sequencer for the NABU MegaMapper: fires NMI on virtualized-port I/O and
// tracks user/supervisor mode. Optional `TRAP_STATS_EN adds an 8-bit trap counter.
module trap_controller #(
  parameter int NMI_WIDTH    = 4,
  parameter int UNTRAP_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic [7:0] addr,
  input  logic       trap_port_match,
  input  logic       new_isr,
  input  logic       last_isr_untrap,
  input  logic       io_direction,
  input  logic       trap_ack,
  output logic       nmi_n,
  output logic       ignore_next_isr,
  output logic       supervisor,
  output logic       trap_pending,
  output logic [7:0] trap_addr,
`ifdef TRAP_STATS_EN
  output logic       trap_dir,
  output logic [7:0] trap_count
`else
  output logic       trap_dir
`endif
);

  typedef enum logic [2:0] {
    S_USER,
    S_NMI,
    S_ACK,
    S_SUPER,
    S_UNTRAP
  } state_t;

  localparam logic [3:0] NMI_LOAD    = NMI_WIDTH[3:0];
  localparam logic [2:0] UNTRAP_LOAD = UNTRAP_DELAY[2:0];

  state_t     state, state_nx;
  logic [3:0] nmi_cnt, nmi_cnt_nx;
  logic [2:0] untrap_cnt, untrap_cnt_nx;

  // Two-deep history so edges are judged on registered samples only; this is
  // what places the NMI one edge after IORQ is first seen low.
  logic iorq_d1, iorq_d2;
  logic m1_d1, m1_d2;
  logic untrap_d1, untrap_d2;

  logic io_start, m1_end, retn_rise, trap_set;

  assign io_start  = iorq_d2 & ~iorq_d1 & m1_d1;
  assign m1_end    = m1_d1 & ~m1_d2;
  assign retn_rise = untrap_d1 & ~untrap_d2;
  assign trap_set  = (state == S_USER) & io_start & trap_port_match;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    nmi_cnt_nx    = nmi_cnt;
    untrap_cnt_nx = untrap_cnt;
    unique case (state)
      S_USER: begin
        if (trap_set) begin
          nmi_cnt_nx = NMI_LOAD;
          state_nx   = S_NMI;
        end
      end
      S_NMI: begin
        if (nmi_cnt <= 4'd1) begin
          nmi_cnt_nx = 4'd0;
          state_nx   = S_ACK;
        end else begin
          nmi_cnt_nx = nmi_cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (m1_end) state_nx = S_SUPER;
      end
      S_SUPER: begin
        if (retn_rise) begin
          untrap_cnt_nx = UNTRAP_LOAD;
          state_nx      = S_UNTRAP;
        end
      end
      S_UNTRAP: begin
        if (retn_rise) begin
          untrap_cnt_nx = UNTRAP_LOAD;
        end else if (m1_end && new_isr) begin
          if (untrap_cnt <= 3'd1) begin
            untrap_cnt_nx = 3'd0;
            state_nx      = S_USER;
          end else begin
            untrap_cnt_nx = untrap_cnt - 3'd1;
          end
        end
      end
      default: state_nx = S_USER;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_USER;
      nmi_cnt         <= 4'd0;
      untrap_cnt      <= 3'd0;
      iorq_d1         <= 1'b1;
      iorq_d2         <= 1'b1;
      m1_d1           <= 1'b1;
      m1_d2           <= 1'b1;
      untrap_d1       <= 1'b0;
      untrap_d2       <= 1'b0;
      nmi_n           <= 1'b1;
      ignore_next_isr <= 1'b0;
      supervisor      <= 1'b0;
      trap_pending    <= 1'b0;
      trap_addr       <= 8'h00;
      trap_dir        <= 1'b0;
    end else begin
      state      <= state_nx;
      nmi_cnt    <= nmi_cnt_nx;
      untrap_cnt <= untrap_cnt_nx;
      iorq_d1    <= iorq_n;
      iorq_d2    <= iorq_d1;
      m1_d1      <= m1_n;
      m1_d2      <= m1_d1;
      untrap_d1  <= last_isr_untrap;
      untrap_d2  <= untrap_d1;

      // Outputs are decoded from the next state so they change on the same
      // edge as the state itself.
      nmi_n           <= (state_nx != S_NMI);
      ignore_next_isr <= (state_nx == S_NMI) || (state_nx == S_ACK);
      supervisor      <= (state_nx != S_USER);

      if (trap_set) begin
        trap_pending <= 1'b1;
        trap_addr    <= addr;
        trap_dir     <= io_direction;
      end else if (trap_ack) begin
        trap_pending <= 1'b0;
      end
    end
  end

`ifdef TRAP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        trap_count <= 8'h00;
    else if (trap_set) trap_count <= trap_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: a scoreboard queue holds expected trap
// records, popped when nmi_n falls. Define TRAP_STATS_EN to cover trap_count.
module tb_trap_controller;

  localparam int NW = 4;
  localparam int UD = 1;

  typedef struct {
    logic [7:0] addr;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m1_n, iorq_n;
  logic [7:0] addr;
  logic       trap_port_match, new_isr, last_isr_untrap, io_direction, trap_ack;
  logic       nmi_n, ignore_next_isr, supervisor, trap_pending, trap_dir;
  logic [7:0] trap_addr;
`ifdef TRAP_STATS_EN
  logic [7:0] trap_count;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_prev = 1'b1;
  logic [7:0] cnt_model = 8'h00;

  always #5 clk = ~clk;

  trap_controller #(.NMI_WIDTH(NW), .UNTRAP_DELAY(UD)) dut (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .iorq_n(iorq_n), .addr(addr),
    .trap_port_match(trap_port_match), .new_isr(new_isr),
    .last_isr_untrap(last_isr_untrap), .io_direction(io_direction),
    .trap_ack(trap_ack), .nmi_n(nmi_n), .ignore_next_isr(ignore_next_isr),
    .supervisor(supervisor), .trap_pending(trap_pending),
    .trap_addr(trap_addr),
`ifdef TRAP_STATS_EN
    .trap_dir(trap_dir),
    .trap_count(trap_count)
`else
    .trap_dir(trap_dir)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every nmi_n fall must match the oldest expected trap.
  always begin
    @(posedge clk);
    #1;
    if (mon_prev && !nmi_n) begin
      if (sb_q.size() == 0) begin
        check("nmi_unexpected", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        cnt_model = cnt_model + 8'h01;
        check("sb_trap_addr", trap_addr, mon_e.addr);
        check("sb_trap_dir", trap_dir, mon_e.dir);
        check("sb_pending", trap_pending, 1);
        check("sb_supervisor", supervisor, 1);
`ifdef TRAP_STATS_EN
        check("sb_trap_count", trap_count, cnt_model);
`endif
      end
    end
    mon_prev = nmi_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_io(input logic [7:0] a, input logic match, input logic dir, input logic m1);
    iorq_n = 1'b0; m1_n = m1; addr = a; trap_port_match = match; io_direction = dir;
  endtask

  task automatic end_io();
    iorq_n = 1'b1; m1_n = 1'b1; trap_port_match = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    cnt_model = 8'h00;
  endtask

  // Trapped I/O: checks latency and that nmi_n is low for exactly NW cycles.
  task automatic trap(input logic [7:0] a, input logic dir, input logic ack_same);
    sb_q.push_back('{addr: a, dir: dir});
    start_io(a, 1'b1, dir, 1'b1);
    tick();
    check("nmi_pre", nmi_n, 1);
    trap_ack = ack_same;
    tick();
    trap_ack = 1'b0;
    end_io();
    for (int i = 0; i < NW; i++) begin
      check("nmi_low", nmi_n, 0);
      check("ign_nmi", ignore_next_isr, 1);
      tick();
    end
    check("nmi_release", nmi_n, 1);
    check("ign_ack", ignore_next_isr, 1);
    check("sup_ack", supervisor, 1);
  endtask

  task automatic ack_fetch();
    m1_n = 1'b0;
    tick(2);
    m1_n = 1'b1;
    tick();
    check("ign_hold", ignore_next_isr, 1);
    tick();
    check("ign_drop", ignore_next_isr, 0);
    check("sup_super", supervisor, 1);
  endtask

  task automatic super_io(input logic [7:0] held);
    start_io(8'h41, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("super_no_nmi", nmi_n, 1);
    end
    end_io();
    tick();
    check("addr_hold", trap_addr, held);
  endtask

  task automatic retn();
    last_isr_untrap = 1'b1;
    tick();
    last_isr_untrap = 1'b0;
    tick();
    check("sup_untrap", supervisor, 1);
  endtask

  task automatic final_fetch();
    new_isr = 1'b1;
    m1_n = 1'b0;
    tick();
    m1_n = 1'b1;
    tick();
    check("sup_pre_end", supervisor, 1);
    tick();
    new_isr = 1'b0;
    check("sup_user", supervisor, 0);
    check("nmi_user", nmi_n, 1);
  endtask

  task automatic full_cycle(input logic [7:0] a, input logic dir);
    trap(a, dir, 1'b0);
    ack_fetch();
    retn();
    final_fetch();
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1; addr = 8'h00;
    trap_port_match = 1'b0; new_isr = 1'b0; last_isr_untrap = 1'b0;
    io_direction = 1'b0; trap_ack = 1'b0;
    do_reset();
    tick(2);

    check("rst_nmi", nmi_n, 1);
    check("rst_ign", ignore_next_isr, 0);
    check("rst_sup", supervisor, 0);
    check("rst_pend", trap_pending, 0);
    check("rst_addr", trap_addr, 8'h00);
    check("rst_dir", trap_dir, 0);
`ifdef TRAP_STATS_EN
    check("rst_count", trap_count, 8'h00);
`endif

    // Unmatched IN, then interrupt acknowledge on a matched port: no trap.
    start_io(8'h10, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("unmatched_nmi", nmi_n, 1);
      check("unmatched_sup", supervisor, 0);
    end
    end_io();
    tick(2);
    start_io(8'h40, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("intack_nmi", nmi_n, 1);
    end
    end_io();
    tick(2);
    check("intack_sup", supervisor, 0);

    // Full cycle with a matched I/O in SUPER and a late trap_ack.
    trap(8'h40, 1'b0, 1'b0);
    ack_fetch();
    super_io(8'h40);
    check("pend_super", trap_pending, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("ack_clear", trap_pending, 0);
    check("ack_sup", supervisor, 1);
    check("ack_ign", ignore_next_isr, 0);
    retn();
    final_fetch();
    tick(2);

    // trap_ack coinciding with the trap: set wins.
    trap(8'h7E, 1'b1, 1'b1);
    ack_fetch();
    retn();
    final_fetch();
    check("pend_hold", trap_pending, 1);
    check("dir_hold", trap_dir, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("ack_user", trap_pending, 0);
    tick(2);

    for (int i = 0; i < 3; i++) full_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Reset asserted during the second NMI cycle.
    sb_q.push_back('{addr: 8'h22, dir: 1'b0});
    start_io(8'h22, 1'b1, 1'b0, 1'b1);
    tick(2);
    end_io();
    tick();
    check("mid_nmi_low", nmi_n, 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_nmi", nmi_n, 1);
    check("mid_rst_sup", supervisor, 0);
    check("mid_rst_pend", trap_pending, 0);
    check("mid_rst_ign", ignore_next_isr, 0);
    rst_n = 1'b1;
    cnt_model = 8'h00;
    tick(4);
    check("post_rst_nmi", nmi_n, 1);

`ifdef TRAP_STATS_EN
    do_reset();
    tick(2);
    for (int i = 0; i < 255; i++) full_cycle(8'(i), 1'(i));
    check("count_ff", trap_count, 8'hFF);
    full_cycle(8'h55, 1'b1);
    check("count_wrap", trap_count, 8'h00);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
